// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: op codes, FSM states and widths.
// Operand/HI/LO width and the RUN iteration count are fixed here and shared by all muldiv files.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    RUN  = ST_RUN,
    FIX  = ST_FIX
  } state_t;

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide; purely combinational.
// Multiply: acc = {carry, hi, lo}. Divide: acc[63:32] = remainder, acc[31:0] = quotient/dividend.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN:0]   acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN:0]   acc_next,
  output logic              qbit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, operand};
    qbit     = 1'b0;
    acc_next = {1'b0, sum, acc[XLEN-1:1]};
    if (is_div) begin
      // The remainder stays below the divisor, so diff[XLEN] is exactly the borrow.
      qbit     = ~diff[XLEN];
      acc_next = {1'b0, (qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: 35 cycles from start to done, busy for 34 of them.
// While busy, HI/LO accesses from the pipeline raise stall and are not performed; start is ignored.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hilo_rd,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t            state;
  logic [1:0]        op_q;
  logic [XLEN-1:0]   rs_q;
  logic [XLEN-1:0]   rt_q;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN:0]   acc;
  logic [2*XLEN:0]   step_acc;
  logic              step_qbit;
  logic [5:0]        cnt;
  logic              neg_res;
  logic              neg_rem;
  logic              div0;
  logic              is_div;
  logic              is_signed;
  logic [XLEN-1:0]   rs_abs;
  logic [XLEN-1:0]   rt_abs;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;
  logic [2*XLEN-1:0] prod;

  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign rs_abs    = (is_signed && rs_q[XLEN-1]) ? -rs_q : rs_q;
  assign rt_abs    = (is_signed && rt_q[XLEN-1]) ? -rt_q : rt_q;
  assign stall     = busy & (hilo_rd | hi_we | lo_we | start);

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (step_acc),
    .qbit     (step_qbit)
  );

  always_comb begin
    prod   = neg_res ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = rs_q;
        res_lo = DIV0_LO;
      end else begin
        res_hi = neg_rem ? -rem : rem;
        res_lo = neg_res ? -quo : quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opnd    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q  <= op;
            rs_q  <= rs_val;
            rt_q  <= rt_val;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          // Multiplier sits in the low half of acc; dividend starts as the quotient field.
          if (is_div) begin
            acc  <= {{(XLEN+1){1'b0}}, rs_abs};
            opnd <= rt_abs;
          end else begin
            acc  <= {{(XLEN+1){1'b0}}, rt_abs};
            opnd <= rs_abs;
          end
          neg_res <= is_signed & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
          neg_rem <= is_signed & rs_q[XLEN-1];
          div0    <= (rt_q == '0);
          cnt     <= '0;
          state   <= RUN;
        end
        RUN: begin
          acc <= {step_acc[2*XLEN:1], step_acc[0] | step_qbit};
          cnt <= cnt + 6'd1;
          if (cnt == 6'(ITERS - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed corner cases, pipeline hazards, reset abort and random ops
// checked against an arithmetic reference of HI/LO and the fixed 35-cycle completion.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hilo_rd = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .hilo_rd (hilo_rd),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {HI, LO} computed straight from the instruction semantics.
  function automatic logic [63:0] ref_hilo(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ref_hilo = '0;
    if (o == OP_MULT) ref_hilo = sa * sb;
    else if (o == OP_MULTU) ref_hilo = ua * ub;
    else if (b == 32'h0) ref_hilo = {a, 32'hFFFF_FFFF};
    else if (o == OP_DIV) begin
      q = sa / sb;
      r = sa % sb;
      ref_hilo = {r[31:0], q[31:0]};
    end else begin
      q = longint'(ua / ub);
      r = longint'(ua % ub);
      ref_hilo = {r[31:0], q[31:0]};
    end
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
  endtask

  // Called at the negedge of the launch cycle; returns at the negedge of the done cycle.
  task automatic finish_op(input string tag, input logic [63:0] exp, input bit hz);
    int lat;
    lat = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (hz) begin
        hilo_rd = 1'b0;
        hi_we   = 1'b0;
        start   = 1'b0;
        if (cyc == 5) hilo_rd = 1'b1;
        if (cyc == 10) begin
          start = 1'b1; op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd3;
        end
        if (cyc == 20) begin
          hi_we = 1'b1; wdata = 32'hAAAA;
        end
        #1;
        if (cyc == 5)  chk({tag, "_stall_rd"}, 64'(stall), 64'd1);
        if (cyc == 10) chk({tag, "_stall_start"}, 64'(stall), 64'd1);
        if (cyc == 20) chk({tag, "_stall_hiwe"}, 64'(stall), 64'd1);
        if (cyc == 6)  chk({tag, "_nostall"}, 64'(stall), 64'd0);
        if (cyc == 21) chk({tag, "_hi_held"}, 64'(hi), 64'(m_hi));
      end
      if (done) begin
        lat = cyc;
        break;
      end
      if (cyc <= 34) chk({tag, "_busy"}, 64'(busy), 64'd1);
    end
    chk({tag, "_latency"}, 64'(lat), 64'd35);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_hilo"}, {hi, lo}, exp);
  endtask

  task automatic idle_write();
    logic [31:0] d;
    d     = $urandom;
    hi_we = 1'($urandom_range(0, 1));
    lo_we = 1'($urandom_range(0, 1));
    wdata = d;
    #1;
    chk("idle_stall", 64'(stall), 64'd0);
    if (hi_we) m_hi = d;
    if (lo_we) m_lo = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    chk("idle_hi", 64'(hi), 64'(m_hi));
    chk("idle_lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] e;
    int dcount;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases, issued back to back in each done cycle.
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 64'hFFFF_FFFE_0000_0001, 1'b0);
    launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult_neg", 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_b2b", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    launch(OP_DIVU, 32'h1234_5678, 32'h0);
    finish_op("divu_zero", 64'h1234_5678_FFFF_FFFF, 1'b0);
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 64'h0000_0000_8000_0000, 1'b0);
    m_hi = 32'h0;
    m_lo = 32'h8000_0000;

    launch(OP_MULTU, 32'd6, 32'd7);
    finish_op("hazard", {32'h0, 32'd42}, 1'b1);
    m_hi = 32'h0;
    m_lo = 32'd42;
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 64'd0);
    chk("hazard_hold", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) idle_write();
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      e = ref_hilo(o, a, b);
      launch(o, a, b);
      finish_op($sformatf("rnd%0d_op%0d", i, o), e, 1'b0);
      m_hi = e[63:32];
      m_lo = e[31:0];
    end

    // Reset in the middle of a divide aborts it without touching HI/LO afterwards.
    launch(OP_DIV, 32'd1000, 32'd7);
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    chk("abort_hilo_late", {hi, lo}, 64'd0);

    lo_we = 1'b1;
    wdata = 32'h55;
    #1;
    chk("mtlo_stall", 64'(stall), 64'd0);
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h55);
    chk("mtlo_hi", 64'(hi), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for MULT, MULTU, DIV and DIVU, with HI/LO register ownership.
- Sits beside the single-cycle execution ALU in the EX stage. EX hands it operands on a start strobe, and it raises busy/stall until HI/LO are final.
- Implements iterative shift-add multiply and restoring divide (one bit per cycle), then applies sign fix-up.
- Also arbitrates HI/LO access between its own result writes and MTHI/MTLO/MFHI/MFLO from the pipeline.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITERS, 32, iteration count of the RUN state; always equals XLEN.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high (already decided)
- start  in  1  request strobe, sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  XLEN  multiplicand or dividend
- rt_val  in  XLEN  multiplier or divisor
- hilo_rd  in  1  EX holds an MFHI/MFLO this cycle
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  XLEN  MTHI/MTLO data
- busy  out  1  operation in flight
- done  out  1  one-cycle completion pulse
- stall  out  1  freeze the pipeline
- hi  out  XLEN  HI register
- lo  out  XLEN  LO register

Behaviour:
- Reset: state IDLE; busy=0, done=0, stall=0, hi=0, lo=0; all iteration registers cleared. Reset asserted mid-operation aborts it on the next edge with no HI/LO update.
- States: IDLE -> PREP -> RUN -> FIX -> IDLE.
  - IDLE, start=1: latch op, rs_val, rt_val; go to PREP.
  - PREP: for signed ops, take absolute values into 32-bit unsigned working registers and record result/remainder sign flags; clear the 6-bit iteration counter; go to RUN.
  - RUN: exactly ITERS cycles, counter increments each cycle, leave when counter=ITERS-1.
    - Multiply: 65-bit accumulator; add the multiplicand to the upper half when acc[0]=1, then shift right by 1.
    - Divide: restoring step; shift the {rem, quo} pair left, trial-subtract the divisor with a 33-bit difference, keep the result if non-negative and set the quotient bit.
  - FIX: apply signs.
    - Product is negated (64-bit two's complement) when operand signs differ.
    - Quotient is negated when signs differ; remainder takes the dividend's sign.
    - Write HI/LO; go to IDLE.
- Timing: start sampled at edge N. busy=1 in cycles N+1..N+34. HI/LO hold the new values and done=1 in cycle N+35 only.
- A new start in the done cycle is accepted (back-to-back operation). start while busy is ignored, with no queueing.
- Output map: multiply gives HI=product[63:32], LO=product[31:0]. Divide gives LO=quotient, HI=remainder.
- Divide by zero: same latency, no trap. HI=rs_val (unmodified), LO=0xFFFFFFFF, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; this falls out of the absolute-value path.
- stall = busy & (hilo_rd | hi_we | lo_we | start).
- hi_we/lo_we:
  - Write hi/lo at the edge only when busy=0.
  - While busy they are held off by stall and not performed.
  - If FIX and hi_we/lo_we coincide, the result write wins.
- hi/lo are outputs of registers, with no combinational path from the inputs.

Decomposition:
- Shared package muldiv_pkg:
  - op codes: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encoding: IDLE/PREP/RUN/FIX as 2-bit localparams
  - DIV0_LO constant 0xFFFFFFFF
  - ITERS
- One natural sub-module, muldiv_step: purely combinational single-iteration datapath.
  - Inputs: mode, accumulator/remainder, operand.
  - Output: next accumulator/remainder and quotient bit.
  - Instantiated once in muldiv_ctrl; the controller holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF, start at edge N -> busy in N+1..N+34, done only in N+35, HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7) rt=2, started in the done cycle -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=0x12345678 rt=0 -> HI=0x12345678, LO=0xFFFFFFFF after 35 cycles. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Hazards during MULTU 6*7:
  - hilo_rd=1 at N+5 -> stall=1 that cycle.
  - start with op=DIVU at N+10 -> ignored; final LO=42, HI=0.
  - hi_we=1 wdata=0xAAAA at N+20 -> stall=1, HI not written.
- Reset and idle writes:
  - rst=1 at N+15 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse.
  - After reset, lo_we=1 wdata=0x55 while idle -> lo=0x55 next cycle, stall=0.
